// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq
//   Avalon-MM input PIO. Each input bit passes through a synchroniser, an optional
//   debounce filter and an edge detector. Detected edges are held in a sticky,
//   write-1-to-clear capture register. irq is the registered OR of captures that
//   are enabled in the interrupt mask.
//
//   Register map (word address):
//     0 DATA     RO    filtered input value
//     1 MODE     RW    [1:0] 00 rising, 01 falling, 10 any edge, 11 capture off
//     2 IRQMASK  RW    1 = capture bit enabled onto irq
//     3 CAPTURE  RW1C  edge capture flags
//
// Ports
//   clk         system clock
//   reset_n     asynchronous reset, active-low
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    read data, one cycle after address
//   irq         level interrupt
module pio_in_edge_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr;
    logic [WIDTH-1:0] rise, fall, det, clr;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Synchroniser chain: stage 0 samples the pin, the last stage feeds the filter.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_debounce
            logic [WIDTH-1:0]            filt_q, filt_d;
            logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

            // A change is accepted only after DEBOUNCE_CYCLES consecutive clocks
            // of disagreement; any agreement restarts the count.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = cnt_q;
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync_s[i] == filt_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        filt_d[i] = sync_s[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign filtered = filt_q;
        end else begin : g_no_debounce
            assign filtered = sync_s;
        end
    endgenerate

    always_comb begin
        rise   = filtered & ~prev_q;
        fall   = ~filtered & prev_q;
        prev_d = filtered;
        case (mode_q)
            2'b00:   det = rise;
            2'b01:   det = fall;
            2'b10:   det = rise | fall;
            default: det = '0;
        endcase

        clr    = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // A fresh edge overrides a same-cycle clear of that bit.
        cap_d  = (cap_q & ~clr) | det;

        mode_d = (wr && address == 2'd1) ? writedata[1:0] : mode_q;
        mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

        // irq follows the registered capture/mask, one clock behind them.
        irq_d  = |(cap_q & mask_q);

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = filtered;
            2'd1:    readdata_d[1:0]       = mode_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            default: readdata_d[WIDTH-1:0] = cap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            cap_q      <= '0;
            mask_q     <= '0;
            mode_q     <= 2'b00;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            cap_q      <= cap_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
module tb_pio_in_edge_irq;

    localparam int RD0 = 0, IRQ0 = 1, RD1 = 2, IRQ1 = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address, address1;
    logic        cs0, cs1, write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port0, in_port1;
    logic [31:0] readdata0, readdata1;
    logic        irq0, irq1;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .in_port(in_port0),
        .readdata(readdata0), .irq(irq0)
    );

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address1), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .in_port(in_port1),
        .readdata(readdata1), .irq(irq1)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_i;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act_of(input int sel);
        case (sel)
            RD0:     return readdata0;
            IRQ0:    return {31'b0, irq0};
            RD1:     return readdata1;
            default: return {31'b0, irq1};
        endcase
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Expected value of a registered output 'dly' clock edges from now.
    function automatic void exp_at(input int dly, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.due  = cyc + dly;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endfunction

    // Monitor: after each edge, pop and compare every expectation due now.
    always @(posedge clk) begin
        #1;
        mon_i = 0;
        while (mon_i < sb.size()) begin
            if (sb[mon_i].due == cyc) begin
                check(sb[mon_i].name, act_of(sb[mon_i].sel), sb[mon_i].exp);
                sb.delete(mon_i);
            end else if (sb[mon_i].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: never sampled, due %0d now %0d", sb[mon_i].name, sb[mon_i].due, cyc);
                sb.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
        if (d == 0) begin
            cs0     = 1'b1;
            address = a;
        end else begin
            cs1      = 1'b1;
            address1 = a;
        end
        write_n   = 1'b0;
        writedata = v;
        @(negedge clk);
        cs0     = 1'b0;
        cs1     = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        address1  = 2'd0;
        cs0       = 1'b0;
        cs1       = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
        in_port0  = '0;
        in_port1  = '0;
        tick(3);
        reset_n = 1'b1;

        // Reset values
        address = 2'd0; address1 = 2'd1;
        exp_at(1, RD0, 0, "reset_data"); exp_at(1, IRQ0, 0, "reset_irq");
        exp_at(1, RD1, 0, "reset_mode1"); exp_at(1, IRQ1, 0, "reset_irq1");
        tick(1);
        address = 2'd1; exp_at(1, RD0, 0, "reset_mode"); tick(1);
        address = 2'd2; exp_at(1, RD0, 0, "reset_mask"); tick(1);
        address = 2'd3; exp_at(1, RD0, 0, "reset_cap");  tick(1);

        // 1: rising capture, exact latency, DATA, W1C clear
        wr(0, 2'd2, 32'hFF);
        wr(0, 2'd1, 32'h0);
        address  = 2'd3;
        in_port0 = 8'h01;
        exp_at(3, RD0, 0, "t1_cap_before"); exp_at(4, RD0, 1, "t1_cap");
        exp_at(3, IRQ0, 0, "t1_irq_before"); exp_at(4, IRQ0, 1, "t1_irq");
        tick(5);
        address = 2'd0; exp_at(1, RD0, 1, "t1_data"); tick(1);
        exp_at(1, IRQ0, 1, "t1_irq_at_clr"); exp_at(2, IRQ0, 0, "t1_irq_cleared");
        wr(0, 2'd3, 32'h01);
        address = 2'd3; exp_at(1, RD0, 0, "t1_cap_cleared"); tick(2);

        // 2: falling mode and capture disabled
        wr(0, 2'd1, 32'hFFFF_FFFF);
        address = 2'd1; exp_at(1, RD0, 3, "t2_mode_upper_zero"); tick(1);
        in_port0 = 8'h00; tick(4);
        address = 2'd3; exp_at(1, RD0, 0, "t2_disabled_fall"); tick(1);
        wr(0, 2'd1, 32'h1);
        address  = 2'd3;
        in_port0 = 8'h81; tick(5);
        exp_at(1, RD0, 0, "t2_rise_no_cap"); exp_at(1, IRQ0, 0, "t2_rise_no_irq"); tick(1);
        in_port0 = 8'h00; tick(5);
        exp_at(1, RD0, 32'h81, "t2_fall_cap"); exp_at(1, IRQ0, 1, "t2_fall_irq"); tick(1);
        wr(0, 2'd3, 32'hFF);
        address  = 2'd3;
        in_port0 = 8'h81; tick(5);
        exp_at(1, RD0, 0, "t2_rise_after_clr"); exp_at(1, IRQ0, 0, "t2_irq_after_clr"); tick(1);
        wr(0, 2'd1, 32'h3);
        address  = 2'd3;
        in_port0 = 8'h00; tick(3);
        in_port0 = 8'h81; tick(3);
        in_port0 = 8'h00; tick(4);
        exp_at(1, RD0, 0, "t2_disabled_toggle"); exp_at(1, IRQ0, 0, "t2_disabled_irq"); tick(1);

        // 4: clear collides with a new rise on the same bit
        wr(0, 2'd1, 32'h0);
        in_port0 = 8'h01; tick(5);
        address = 2'd3; exp_at(1, RD0, 1, "t4_setup_cap"); tick(1);
        in_port0 = 8'h00; tick(4);
        in_port0 = 8'h01; tick(2);
        exp_at(1, IRQ0, 1, "t4_irq_e0"); exp_at(2, IRQ0, 1, "t4_irq_e1");
        exp_at(3, IRQ0, 1, "t4_irq_e2");
        wr(0, 2'd3, 32'h01);
        address = 2'd3; exp_at(1, RD0, 1, "t4_cap_kept"); tick(3);
        in_port0 = 8'h00; tick(3);
        wr(0, 2'd3, 32'hFF); tick(2);

        // 5: masking
        wr(0, 2'd2, 32'h00);
        in_port0 = 8'h0F; tick(5);
        address = 2'd3;
        exp_at(1, RD0, 32'h0F, "t5_cap"); exp_at(1, IRQ0, 0, "t5_masked"); tick(1);
        exp_at(1, IRQ0, 0, "t5_irq_at_unmask"); exp_at(2, IRQ0, 1, "t5_unmask");
        wr(0, 2'd2, 32'h04);
        address = 2'd2; exp_at(1, RD0, 32'h04, "t5_mask_rb"); tick(1);
        exp_at(1, IRQ0, 1, "t5_irq_at_clr"); exp_at(2, IRQ0, 0, "t5_clr_bit2");
        wr(0, 2'd3, 32'h04);
        address = 2'd3; exp_at(1, RD0, 32'h0B, "t5_cap_rest"); tick(2);

        // 3: debounce, D = 4
        wr(1, 2'd2, 32'h01);
        address1 = 2'd0;
        in_port1 = 8'h01; tick(3);
        in_port1 = 8'h00; tick(8);
        exp_at(1, RD1, 0, "t3_glitch_data"); exp_at(1, IRQ1, 0, "t3_glitch_irq"); tick(1);
        address1 = 2'd3; exp_at(1, RD1, 0, "t3_glitch_cap"); tick(1);
        address1 = 2'd0;
        in_port1 = 8'h01;
        exp_at(6, RD1, 0, "t3_data_before"); exp_at(7, RD1, 1, "t3_data");
        exp_at(7, IRQ1, 0, "t3_irq_before"); exp_at(8, IRQ1, 1, "t3_irq");
        tick(9);
        address1 = 2'd3; exp_at(1, RD1, 1, "t3_cap"); tick(2);

        // 6: reset mid-operation
        wr(0, 2'd2, 32'hFF);
        in_port0 = 8'h00;
        in_port1 = 8'h00;
        tick(3);
        exp_at(1, IRQ0, 1, "t6_irq0_pending"); exp_at(1, IRQ1, 1, "t6_irq1_pending");
        tick(1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_rd0", readdata0, 0);
        check("t6_rst_irq0", {31'b0, irq0}, 0);
        check("t6_rst_rd1", readdata1, 0);
        check("t6_rst_irq1", {31'b0, irq1}, 0);
        tick(2);
        reset_n  = 1'b1;
        address  = 2'd0;
        address1 = 2'd3;
        exp_at(1, RD0, 0, "t6_data"); exp_at(1, RD1, 0, "t6_cap1"); tick(1);
        address = 2'd1; address1 = 2'd1;
        exp_at(1, RD0, 0, "t6_mode"); exp_at(1, RD1, 0, "t6_mode1"); tick(1);
        address = 2'd2; exp_at(1, RD0, 0, "t6_mask"); tick(1);
        address = 2'd3; address1 = 2'd3; tick(6);
        exp_at(1, RD0, 0, "t6_no_spurious_cap"); exp_at(1, RD1, 0, "t6_no_spurious_cap1");
        exp_at(1, IRQ0, 0, "t6_irq0"); exp_at(1, IRQ1, 0, "t6_irq1");
        tick(1);

        tick(10);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
